// File: rtl/eth_classify.sv
// Ethernet first-word classifier: decodes destination MAC, VLAN tag and ethertype of each
// packet's first word and queues one result per packet in a small first-word fall-through FIFO.
module eth_classify #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned MAC_WIDTH            = 48,
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned FIFO_DEPTH_BITS      = 2,
  parameter int unsigned VLAN_EN              = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] i_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] i_tuser,
  input  logic                            i_pkt_word1,
  input  logic [NUM_PORTS*MAC_WIDTH-1:0]  i_macs,
  input  logic                            i_rd_from_magic,
  output logic                            o_is_for_us,
  output logic                            o_is_bmcast,
  output logic                            o_is_arp,
  output logic                            o_is_ipv4,
  output logic                            o_is_ipv6,
  output logic                            o_is_vlan,
  output logic [11:0]                     o_vlan_id,
  output logic                            o_port_err,
  output logic                            o_eth_out_valid,
  output logic                            o_overflow,
  output logic [31:0]                     o_pkt_cnt,
  output logic [31:0]                     o_drop_cnt
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;

  localparam logic [15:0] EtIpv4 = 16'h0800;
  localparam logic [15:0] EtArp  = 16'h0806;
  localparam logic [15:0] EtIpv6 = 16'h86DD;
  localparam logic [15:0] Tpid   = 16'h8100;

  typedef struct packed {
    logic        for_us;
    logic        bmcast;
    logic        arp;
    logic        ipv4;
    logic        ipv6;
    logic        vlan;
    logic [11:0] vlan_id;
    logic        port_err;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Classification of the current first word
  // ---------------------------------------------------------------------------
  logic [MAC_WIDTH-1:0] dmac;
  logic [15:0]          tpid;
  logic [15:0]          eff_type;
  logic [7:0]           src_sel;
  logic                 port_hit;
  logic                 mac_match;
  entry_t               new_entry;

  assign dmac    = i_tdata[255 -: MAC_WIDTH];
  assign tpid    = i_tdata[159:144];
  // Only even bit positions of the source byte name MAC ports; odd ones are CPU queues.
  assign src_sel = i_tuser[23:16] & 8'h55;

  always_comb begin
    port_hit  = 1'b0;
    mac_match = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (src_sel == 8'(32'd1 << (2 * p))) begin
        port_hit  = 1'b1;
        mac_match = (dmac == i_macs[p*MAC_WIDTH +: MAC_WIDTH]);
      end
    end
  end

  always_comb begin
    new_entry          = '0;
    new_entry.vlan     = (VLAN_EN != 0) && (tpid == Tpid);
    new_entry.vlan_id  = new_entry.vlan ? i_tdata[139:128] : 12'd0;
    eff_type           = new_entry.vlan ? i_tdata[127:112] : tpid;
    new_entry.ipv4     = (eff_type == EtIpv4);
    new_entry.arp      = (eff_type == EtArp);
    new_entry.ipv6     = (eff_type == EtIpv6);
    new_entry.bmcast   = i_tdata[248];
    new_entry.port_err = !port_hit;
    new_entry.for_us   = new_entry.bmcast || (port_hit && mac_match);
  end

  // ---------------------------------------------------------------------------
  // Result FIFO and status
  // ---------------------------------------------------------------------------
  entry_t                     mem_q [Depth];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [31:0]                pkt_cnt_q, pkt_cnt_d;
  logic [31:0]                drop_cnt_q, drop_cnt_d;
  logic                       empty, full, pop, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));
  assign pop   = i_rd_from_magic && !empty;
  // A pop frees the head slot this cycle, so a write on a full FIFO still fits.
  assign push  = i_pkt_word1 && (!full || pop);
  assign drop  = i_pkt_word1 && full && !pop;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q || drop;
    pkt_cnt_d  = (push && (pkt_cnt_q != '1)) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 32'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  entry_t head;

  assign head            = mem_q[rd_ptr_q];
  assign o_is_for_us     = head.for_us;
  assign o_is_bmcast     = head.bmcast;
  assign o_is_arp        = head.arp;
  assign o_is_ipv4       = head.ipv4;
  assign o_is_ipv6       = head.ipv6;
  assign o_is_vlan       = head.vlan;
  assign o_vlan_id       = head.vlan_id;
  assign o_port_err      = head.port_err;
  assign o_eth_out_valid = !empty;
  assign o_overflow      = overflow_q;
  assign o_pkt_cnt       = pkt_cnt_q;
  assign o_drop_cnt      = drop_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{i_tdata, i_tuser};

endmodule
